// File: rtl/fpu_issue_ctrl_if.sv
// Bus bundle between the EX-stage issue path, the FPU datapath and writeback.
// The controller uses the master view; the surrounding pipeline/FPU uses slave.
interface fpu_issue_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
);
   logic             flush;
   logic             issue_valid;
   logic [3:0]       issue_fpuOp;
   logic [2:0]       issue_func3;
   logic             issue_rs1_0;
   logic [WIDTH-1:0] issue_dataA;
   logic [WIDTH-1:0] issue_dataB;
   logic [REGW-1:0]  issue_rd;
   logic             issue_rd_fp;

   logic             fpu_sel;
   logic [3:0]       fpu_op;
   logic [2:0]       fpu_func3;
   logic             fpu_rs1_0;
   logic [WIDTH-1:0] fpu_dataA;
   logic [WIDTH-1:0] fpu_dataB;
   logic [WIDTH-1:0] fpu_result;

   logic             stall;
   logic             wb_valid;
   logic [WIDTH-1:0] wb_data;
   logic [REGW-1:0]  wb_rd;
   logic             wb_rd_fp;

   modport master (
      input  flush, issue_valid, issue_fpuOp, issue_func3, issue_rs1_0,
             issue_dataA, issue_dataB, issue_rd, issue_rd_fp, fpu_result,
      output fpu_sel, fpu_op, fpu_func3, fpu_rs1_0, fpu_dataA, fpu_dataB,
             stall, wb_valid, wb_data, wb_rd, wb_rd_fp
   );

   modport slave (
      output flush, issue_valid, issue_fpuOp, issue_func3, issue_rs1_0,
             issue_dataA, issue_dataB, issue_rd, issue_rd_fp, fpu_result,
      input  fpu_sel, fpu_op, fpu_func3, fpu_rs1_0, fpu_dataA, fpu_dataB,
             stall, wb_valid, wb_data, wb_rd, wb_rd_fp
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue sequencer: accepts one FP op, holds its operands on the FPU inputs
// for the op's fixed latency while stalling the pipeline, then hands the
// captured result to writeback as a single valid beat.
module fpu_issue_ctrl #(
   parameter int WIDTH = 32,
   parameter int REGW  = 5
) (
   input logic              clock,
   input logic              clock_reset,
   fpu_issue_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [4:0]       count;
   logic [4:0]       count_next;
   logic [4:0]       lat;
   logic             accept;
   logic             capture;

   logic [3:0]       op_r;
   logic [2:0]       func3_r;
   logic             rs1_0_r;
   logic [WIDTH-1:0] data_a_r;
   logic [WIDTH-1:0] data_b_r;
   logic [REGW-1:0]  rd_r;
   logic             rd_fp_r;
   logic [WIDTH-1:0] result_r;

   // Cycles the FPU needs beyond the first RUN cycle; count runs 0..lat, so
   // the 5-bit counter never wraps even for sqrt.
   function automatic logic [4:0] op_latency(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001: op_latency = 5'd7;
         4'b0010:          op_latency = 5'd5;
         4'b0011:          op_latency = 5'd6;
         4'b0100:          op_latency = 5'd0;
         4'b0101:          op_latency = 5'd1;
         4'b0110:          op_latency = 5'd16;
         4'b0111:          op_latency = 5'd1;
         4'b1000, 4'b1001: op_latency = 5'd6;
         default:          op_latency = 5'd0;
      endcase
   endfunction

   assign lat = op_latency(op_r);

   // State and latency counter register.
   always_ff @(posedge clock or negedge clock_reset) begin
      if (!clock_reset) begin
         state <= IDLE;
         count <= 5'd0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Next-state logic; flush kills whatever is in flight and nothing is
   // accepted in DONE because that EX instruction is the one retiring.
   always_comb begin
      state_next = state;
      count_next = count;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.issue_valid && !bus.flush) begin
               accept     = 1'b1;
               count_next = 5'd0;
               state_next = RUN;
            end
         end
         RUN: begin
            if (bus.flush) begin
               count_next = 5'd0;
               state_next = IDLE;
            end else if (count == lat) begin
               capture    = 1'b1;
               count_next = 5'd0;
               state_next = DONE;
            end else begin
               count_next = count + 5'd1;
            end
         end
         DONE: begin
            count_next = 5'd0;
            state_next = IDLE;
         end
         default: begin
            count_next = 5'd0;
            state_next = IDLE;
         end
      endcase
   end

   // Operand/control capture at acceptance; held stable until the next accept.
   always_ff @(posedge clock or negedge clock_reset) begin
      if (!clock_reset) begin
         op_r     <= '0;
         func3_r  <= '0;
         rs1_0_r  <= 1'b0;
         data_a_r <= '0;
         data_b_r <= '0;
         rd_r     <= '0;
         rd_fp_r  <= 1'b0;
      end else if (accept) begin
         op_r     <= bus.issue_fpuOp;
         func3_r  <= bus.issue_func3;
         rs1_0_r  <= bus.issue_rs1_0;
         data_a_r <= bus.issue_dataA;
         data_b_r <= bus.issue_dataB;
         rd_r     <= bus.issue_rd;
         rd_fp_r  <= bus.issue_rd_fp;
      end
   end

   // Result capture on the last RUN cycle.
   always_ff @(posedge clock or negedge clock_reset) begin
      if (!clock_reset) begin
         result_r <= '0;
      end else if (capture) begin
         result_r <= bus.fpu_result;
      end
   end

   assign bus.fpu_sel   = (state == RUN);
   assign bus.fpu_op    = op_r;
   assign bus.fpu_func3 = func3_r;
   assign bus.fpu_rs1_0 = rs1_0_r;
   assign bus.fpu_dataA = data_a_r;
   assign bus.fpu_dataB = data_b_r;

   assign bus.stall     = (state == RUN) ||
                          ((state == IDLE) && bus.issue_valid && !bus.flush);

   // A flush landing on the DONE cycle must still suppress the beat.
   assign bus.wb_valid  = (state == DONE) && !bus.flush;
   assign bus.wb_data   = result_r;
   assign bus.wb_rd     = rd_r;
   assign bus.wb_rd_fp  = rd_fp_r;

endmodule
